// File: rtl/ysyx_22041211_skid_reg_if.sv
// Handshake bundle for ysyx_22041211_skid_reg.
// Carries the upstream channel (in_*) and the downstream channel (out_*).
// Both channels use valid/ready: a beat moves on a rising clk edge where
// valid && ready are both high; valid must not wait on ready, and a source
// holding valid keeps its payload stable until the beat moves.
// dbg_state mirrors the buffer FSM state so checkers can bind to it.
// "master" is the side that produces upstream beats and consumes the output;
// "slave" is the skid register itself.
interface ysyx_22041211_skid_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       dbg_state;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, dbg_state
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, dbg_state
    );
endinterface

// File: rtl/ysyx_22041211_skid_reg.sv
// Two-entry skid register (main + skid) that cuts every combinational path
// between the upstream and downstream handshakes while keeping full throughput.
// out_data comes straight from the main register; in_ready and out_valid are
// flops updated alongside the state.
// Optional feature: define YSYX_22041211_SKID_REG_STALL_CNT_EN to build a
// saturating counter of cycles where out_valid is high and out_ready is low;
// without it stall_cnt is tied to zero and no counter register exists.
module ysyx_22041211_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    ysyx_22041211_skid_reg_if.slave    bus,
    output logic [31:0]                stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             up_xfer;
    logic             dn_xfer;

    assign up_xfer = bus.in_valid && in_ready_q;
    assign dn_xfer = out_valid_q && bus.out_ready;

    // Buffer FSM: flush beats any transfer; SKID never accepts while it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (up_xfer) begin
                        main_q      <= bus.in_data;
                        state       <= FULL;
                        out_valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (up_xfer && dn_xfer) begin
                        main_q <= bus.in_data;
                    end else if (up_xfer) begin
                        skid_q     <= bus.in_data;
                        state      <= SKID;
                        in_ready_q <= 1'b0;
                    end else if (dn_xfer) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                SKID: begin
                    if (dn_xfer) begin
                        main_q     <= skid_q;
                        state      <= FULL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.dbg_state = state;

`ifdef YSYX_22041211_SKID_REG_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count stalled output cycles, saturating; flush leaves the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else if (out_valid_q && !bus.out_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/ysyx_22041211_skid_reg.md
YSYX_22041211_SKID_REG -- requirements
Module: ysyx_22041211_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the payload width in bits (legal 1..64).
REQ-002 Parameter RESET_VAL, default 0, SHALL set the reset value of both data registers and out_data.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 flush  input  1  SHALL be a synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  SHALL indicate the upstream beat is valid.
REQ-007 in_ready  output  1  SHALL indicate the block accepts an upstream beat this cycle.
REQ-008 in_data  input  WIDTH  SHALL be the upstream payload.
REQ-009 out_valid  output  1  SHALL indicate out_data holds a valid beat.
REQ-010 out_ready  input  1  SHALL indicate downstream accepts the beat.
REQ-011 out_data  output  WIDTH  SHALL be the downstream payload, driven directly from the main register.
REQ-012 stall_cnt  output  32  SHALL be the stall counter (see Configuration).

Function
REQ-013 Beats SHALL transfer upstream when in_valid && in_ready and downstream when out_valid && out_ready at a rising clk edge.
REQ-014 The block SHALL hold up to two entries, main and skid, tracked by state EMPTY / FULL / SKID.
REQ-015 in_ready SHALL equal (state != SKID) and SHALL have no combinational path from out_ready, in_valid or flush.
REQ-016 out_valid SHALL equal (state != EMPTY), with no combinational path from any input.
REQ-017 EMPTY with an upstream transfer: main <= in_data, next state FULL.
REQ-018 FULL with both upstream and downstream transfers: main <= in_data, state stays FULL.
REQ-019 FULL with an upstream transfer only: skid <= in_data, next state SKID, and main is unchanged.
REQ-020 FULL with a downstream transfer only: next state EMPTY.
REQ-021 SKID with a downstream transfer: main <= skid, next state FULL, and no upstream beat is accepted that cycle.
REQ-022 In every other case, state and data registers SHALL hold.
REQ-023 Latency SHALL be one cycle from the upstream transfer to out_valid when the block is EMPTY.
REQ-024 Throughput SHALL be one beat per cycle while out_ready stays high.
REQ-025 Beats SHALL leave in arrival order, with none lost or duplicated.
REQ-026 flush SHALL force next state EMPTY and SHALL take priority over any simultaneous transfer, so a coincident upstream beat is dropped.
REQ-027 Data registers SHALL NOT be cleared by flush.
REQ-028 When out_valid is high and out_ready is low, out_data SHALL stay stable.

Reset
REQ-029 While rst is high: state = EMPTY, main = skid = RESET_VAL, out_valid = 0, in_ready = 1, stall_cnt = 0, all taking effect immediately without waiting for clk.
REQ-030 Reset asserted mid-transfer SHALL discard all entries, and no beat SHALL appear at the output after reset is released until a new upstream transfer.
REQ-031 The first transfer SHALL be possible on the first rising clk edge after rst falls.

Configuration
REQ-032 With macro YSYX_22041211_SKID_REG_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 on each cycle where out_valid && !out_ready.
REQ-033 With the macro defined, stall_cnt SHALL saturate at 32'hFFFF_FFFF, clear on rst, and be unaffected by flush.
REQ-034 With the macro undefined, stall_cnt SHALL be constant 0, no counter register SHALL be synthesised, and all other behaviour SHALL be identical.

Verification
REQ-035 Reset then idle: rst pulse mid-cycle -> immediately out_valid=0, in_ready=1, out_data=RESET_VAL (0).
REQ-036 Streaming: out_ready=1, beats 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 one cycle later each, and in_ready stays 1.
REQ-037 Backpressure: out_ready=0, send 0xA1 then 0xA2 -> in_ready=0 after the second beat, and 0xA3 is held upstream; raise out_ready -> outputs 0xA1, 0xA2, 0xA3 in order, none lost.
REQ-038 Flush: block in SKID holding 0xB1/0xB2, flush=1 with in_valid=1 carrying 0xB3 -> next cycle out_valid=0, in_ready=1, and 0xB3 never emerges.
REQ-039 Async reset mid-stream: rst asserted between edges while in SKID -> out_valid drops before the next edge, and no stale beat appears after release.
REQ-040 Counter (macro defined): hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; with the macro undefined the same stimulus -> stall_cnt=0.
